// File: rtl/pdm_pkg.sv
// Shared PDM constants and width helpers, used by both the modulator and the decimator
// so that their width checks agree.
package pdm_pkg;

    localparam int CIC_ORDER = 3;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    // One guard bit above the worst-case CIC gain of DECIMATION**CIC_ORDER.
    function automatic int acc_width(input int decimation);
        return CIC_ORDER * clog2(decimation) + 1;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/cic_integrator.sv
// Enabled wrap-around accumulator: one integrator stage of the CIC chain.
module cic_integrator
    import pdm_pkg::*;
#(
    parameter int ACC_W = 13
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [ACC_W-1:0] din,
    output logic [ACC_W-1:0] acc
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        if (en) begin
            acc_d = acc_q + din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/pdm_decimator.sv
// 1-bit PDM to unsigned PCM: 3rd-order CIC decimator, saturating rescale and a
// single-entry valid/ready output buffer that reports overwritten samples.
module pdm_decimator
    import pdm_pkg::*;
#(
    parameter int OUTPUT_WIDTH = 8,
    parameter int DECIMATION   = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    pdm_in,
    input  logic                    pdm_valid,
    output logic [OUTPUT_WIDTH-1:0] sample,
    output logic                    sample_valid,
    input  logic                    sample_ready,
    output logic                    overrun
);

    localparam int LOG2_D = clog2(DECIMATION);
    localparam int ACC_W  = acc_width(DECIMATION);
    localparam int SHIFT  = CIC_ORDER * LOG2_D - OUTPUT_WIDTH;
    localparam int CNT_W  = (LOG2_D < 1) ? 1 : LOG2_D;

    if (!is_pow2(DECIMATION) || (DECIMATION < 2) || (SHIFT < 0)) begin : g_param_check
        $error("pdm_decimator: DECIMATION must be a power of two >= 2 with 3*log2(DECIMATION) >= OUTPUT_WIDTH");
    end

    logic [ACC_W-1:0] i1;
    logic [ACC_W-1:0] i2;
    logic [ACC_W-1:0] i3;

    cic_integrator #(.ACC_W(ACC_W)) u_int1 (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (pdm_valid),
        .din     (ACC_W'(pdm_in)),
        .acc     (i1)
    );

    cic_integrator #(.ACC_W(ACC_W)) u_int2 (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (pdm_valid),
        .din     (i1),
        .acc     (i2)
    );

    cic_integrator #(.ACC_W(ACC_W)) u_int3 (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (pdm_valid),
        .din     (i2),
        .acc     (i3)
    );

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [1:0]              warm_q, warm_d;
    logic [ACC_W-1:0]        d1_q, d1_d;
    logic [ACC_W-1:0]        d2_q, d2_d;
    logic [ACC_W-1:0]        d3_q, d3_d;
    logic [OUTPUT_WIDTH-1:0] sample_q, sample_d;
    logic                    valid_q, valid_d;
    logic                    overrun_q, overrun_d;

    logic                    tick;
    logic                    warm_done;
    logic                    load;
    logic                    consume;
    logic [ACC_W-1:0]        c1, c2, c3;
    logic [ACC_W-1:0]        shifted;
    logic [OUTPUT_WIDTH-1:0] scaled;

    always_comb begin
        tick      = pdm_valid && (cnt_q == CNT_W'(DECIMATION - 1));
        warm_done = (warm_q == 2'd3);
        load      = tick && warm_done;
        consume   = valid_q && sample_ready;

        c1 = i3 - d1_q;
        c2 = c1 - d2_q;
        c3 = c2 - d3_q;

        // Full-scale DC lands one bit above the output range; clamp instead of wrapping.
        shifted = c3 >> SHIFT;
        scaled  = (|shifted[ACC_W-1:OUTPUT_WIDTH]) ? {OUTPUT_WIDTH{1'b1}}
                                                   : shifted[OUTPUT_WIDTH-1:0];

        cnt_d     = cnt_q;
        warm_d    = warm_q;
        d1_d      = d1_q;
        d2_d      = d2_q;
        d3_d      = d3_q;
        sample_d  = sample_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;

        if (pdm_valid) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end

        if (tick) begin
            d1_d = i3;
            d2_d = c1;
            d3_d = c2;
            if (!warm_done) begin
                warm_d = warm_q + 2'd1;
            end
        end

        if (load) begin
            sample_d  = scaled;
            valid_d   = 1'b1;
            overrun_d = valid_q && !consume;
        end else if (consume) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            warm_q    <= '0;
            d1_q      <= '0;
            d2_q      <= '0;
            d3_q      <= '0;
            sample_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            warm_q    <= warm_d;
            d1_q      <= d1_d;
            d2_q      <= d2_d;
            d3_q      <= d3_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_pdm_decimator.sv
// Self-checking bench for pdm_decimator: cumulative-sum CIC reference model plus
// directed and randomized PDM streams.
module tb_pdm_decimator;

    localparam int OW   = 8;
    localparam int DEC  = 16;
    localparam int MASK = 8191;

    logic          clk;
    logic          reset_n;
    logic          pdm_in;
    logic          pdm_valid;
    logic [OW-1:0] sample;
    logic          sample_valid;
    logic          sample_ready;
    logic          overrun;

    int n_checks;
    int n_pass;

    // reference model state
    int s1, s2, s3;
    int h1, h2, h3;
    int nbits, nticks;
    bit exp_valid, exp_overrun, exp_load;
    int exp_sample;

    pdm_decimator #(.OUTPUT_WIDTH(OW), .DECIMATION(DEC)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pdm_in       (pdm_in),
        .pdm_valid    (pdm_valid),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void model_reset();
        s1 = 0; s2 = 0; s3 = 0;
        h1 = 0; h2 = 0; h3 = 0;
        nbits = 0; nticks = 0;
        exp_valid = 0; exp_overrun = 0; exp_load = 0; exp_sample = 0;
    endfunction

    // s_k hold the k-fold running sums of all bits before the current one; the
    // decimated output is the third difference of s3 across decimation instants.
    function automatic void model_step(input bit v, input bit b, input bit rdy);
        int c, q, newv;
        bit consume;
        exp_load = 0;
        newv = 0;
        if (v) begin
            nbits++;
            if (nbits % DEC == 0) begin
                nticks++;
                c = (s3 - 3 * h1 + 3 * h2 - h3) & MASK;
                h3 = h2; h2 = h1; h1 = s3;
                q = c / 16;
                newv = (q > 255) ? 255 : q;
                exp_load = (nticks >= 4);
            end
            s3 = (s3 + s2) & MASK;
            s2 = (s2 + s1) & MASK;
            s1 = (s1 + int'(b)) & MASK;
        end
        consume = exp_valid && rdy;
        exp_overrun = exp_load && exp_valid && !consume;
        if (exp_load) begin
            exp_sample = newv;
            exp_valid = 1;
        end else if (consume) begin
            exp_valid = 0;
        end
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        pdm_valid = 1'b0;
        pdm_in = 1'b0;
        sample_ready = 1'b1;
        repeat (2) @(negedge clk);
        model_reset();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (sample_valid !== 1'b0) $display("FAIL reset_valid got=%0b want=0", sample_valid); else n_pass++;
        n_checks++;
        if (sample !== 8'h00) $display("FAIL reset_sample got=%0h want=00", sample); else n_pass++;
        n_checks++;
        if (overrun !== 1'b0) $display("FAIL reset_overrun got=%0b want=0", overrun); else n_pass++;
    endtask

    task automatic test_all_zeros();
        int n_out, first_bit;
        do_reset();
        n_out = 0;
        first_bit = -1;
        for (int i = 0; i < 256; i++) begin
            pdm_valid = 1'b1; pdm_in = 1'b0;
            model_step(1'b1, 1'b0, 1'b1);
            @(negedge clk);
            n_checks++;
            if (sample_valid !== exp_valid) $display("FAIL zeros_valid bit=%0d got=%0b want=%0b", i, sample_valid, exp_valid); else n_pass++;
            if (sample_valid === 1'b1) begin
                n_out++;
                if (first_bit < 0) first_bit = i;
                n_checks++;
                if (sample !== 8'h00) $display("FAIL zeros_sample bit=%0d got=%0h want=00", i, sample); else n_pass++;
            end
        end
        pdm_valid = 1'b0;
        n_checks++;
        if (first_bit !== 63) $display("FAIL zeros_first_valid got_bit=%0d want_bit=63", first_bit); else n_pass++;
        n_checks++;
        if (n_out !== 13) $display("FAIL zeros_count got=%0d want=13", n_out); else n_pass++;
    endtask

    task automatic test_all_ones();
        do_reset();
        for (int i = 0; i < 320; i++) begin
            pdm_valid = 1'b1; pdm_in = 1'b1;
            model_step(1'b1, 1'b1, 1'b1);
            @(negedge clk);
            n_checks++;
            if (sample_valid !== exp_valid) $display("FAIL ones_valid bit=%0d got=%0b want=%0b", i, sample_valid, exp_valid); else n_pass++;
            if (sample_valid === 1'b1) begin
                n_checks++;
                if (sample !== 8'hFF || exp_sample != 255) $display("FAIL ones_sample bit=%0d got=%0h model=%0h want=ff", i, sample, exp_sample); else n_pass++;
            end
        end
        pdm_valid = 1'b0;
    endtask

    task automatic test_alternating(input int gap, output int n_out);
        int last_cyc, cyc;
        bit b;
        do_reset();
        n_out = 0;
        last_cyc = -1;
        cyc = 0;
        for (int i = 0; i < 256; i++) begin
            b = (i % 2 == 0);
            for (int g = 0; g < gap; g++) begin
                pdm_valid = (g == 0); pdm_in = (g == 0) ? b : 1'b0;
                model_step(g == 0, b, 1'b1);
                @(negedge clk);
                cyc++;
                n_checks++;
                if (sample_valid !== exp_valid || overrun !== exp_overrun) $display("FAIL alt_flags gap=%0d bit=%0d got=%0b/%0b want=%0b/%0b", gap, i, sample_valid, overrun, exp_valid, exp_overrun); else n_pass++;
                if (sample_valid === 1'b1) begin
                    n_out++;
                    n_checks++;
                    if (sample !== 8'h80 || exp_sample != 128) $display("FAIL alt_sample gap=%0d bit=%0d got=%0h model=%0h want=80", gap, i, sample, exp_sample); else n_pass++;
                    if (last_cyc >= 0) begin
                        n_checks++;
                        if (cyc - last_cyc !== 16 * gap) $display("FAIL alt_spacing gap=%0d got=%0d want=%0d", gap, cyc - last_cyc, 16 * gap); else n_pass++;
                    end
                    last_cyc = cyc;
                end
            end
        end
        pdm_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        int n_ovr, n_load;
        do_reset();
        sample_ready = 1'b0;
        n_ovr = 0; n_load = 0;
        for (int i = 0; i < 128; i++) begin
            pdm_valid = 1'b1; pdm_in = 1'b1;
            model_step(1'b1, 1'b1, 1'b0);
            if (exp_load) n_load++;
            @(negedge clk);
            if (overrun === 1'b1) n_ovr++;
            n_checks++;
            if (sample_valid !== exp_valid || overrun !== exp_overrun) $display("FAIL bp_flags bit=%0d got=%0b/%0b want=%0b/%0b", i, sample_valid, overrun, exp_valid, exp_overrun); else n_pass++;
            if (exp_valid) begin
                n_checks++;
                if (sample !== 8'hFF) $display("FAIL bp_sample bit=%0d got=%0h want=ff", i, sample); else n_pass++;
            end
        end
        n_checks++;
        if (n_ovr !== n_load - 1) $display("FAIL bp_overrun_count got=%0d want=%0d", n_ovr, n_load - 1); else n_pass++;
        // ready asserted exactly on the cycle of the next load: load and consume coincide
        for (int i = 0; i < 16; i++) begin
            pdm_valid = 1'b1; pdm_in = 1'b1;
            sample_ready = (i == 15);
            model_step(1'b1, 1'b1, i == 15);
            @(negedge clk);
            n_checks++;
            if (sample_valid !== exp_valid || overrun !== exp_overrun) $display("FAIL bp_release_flags i=%0d got=%0b/%0b want=%0b/%0b", i, sample_valid, overrun, exp_valid, exp_overrun); else n_pass++;
        end
        n_checks++;
        if (overrun !== 1'b0 || sample_valid !== 1'b1) $display("FAIL bp_load_consume got=%0b/%0b want=1/0", sample_valid, overrun); else n_pass++;
        sample_ready = 1'b1;
        pdm_valid = 1'b0;
    endtask

    task automatic test_mid_reset();
        int first_bit;
        bit b;
        do_reset();
        sample_ready = 1'b0;
        for (int i = 0; i < 70; i++) begin
            b = 1'($urandom_range(0, 1));
            pdm_valid = 1'b1; pdm_in = b;
            model_step(1'b1, b, 1'b0);
            @(negedge clk);
            n_checks++;
            if (sample_valid !== exp_valid || (exp_valid && sample !== 8'(exp_sample))) $display("FAIL mid_pre bit=%0d got=%0b/%0h want=%0b/%0h", i, sample_valid, sample, exp_valid, exp_sample); else n_pass++;
        end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (sample_valid !== 1'b0 || overrun !== 1'b0) $display("FAIL mid_async got=%0b/%0b want=0/0", sample_valid, overrun); else n_pass++;
        pdm_valid = 1'b0;
        sample_ready = 1'b1;
        @(negedge clk);
        model_reset();
        reset_n = 1'b1;
        first_bit = -1;
        for (int i = 0; i < 80; i++) begin
            b = 1'($urandom_range(0, 1));
            pdm_valid = 1'b1; pdm_in = b;
            model_step(1'b1, b, 1'b1);
            @(negedge clk);
            if (sample_valid === 1'b1 && first_bit < 0) first_bit = i;
            n_checks++;
            if (sample_valid !== exp_valid || (exp_valid && sample !== 8'(exp_sample))) $display("FAIL mid_post bit=%0d got=%0b/%0h want=%0b/%0h", i, sample_valid, sample, exp_valid, exp_sample); else n_pass++;
        end
        n_checks++;
        if (first_bit !== 63) $display("FAIL mid_first_valid got_bit=%0d want_bit=63", first_bit); else n_pass++;
        pdm_valid = 1'b0;
    endtask

    task automatic test_random();
        bit v, b, r;
        do_reset();
        for (int i = 0; i < 1200; i++) begin
            v = ($urandom_range(0, 9) < 7);
            b = ($urandom_range(0, 9) < 6);
            r = ($urandom_range(0, 3) != 0);
            pdm_valid = v; pdm_in = b; sample_ready = r;
            model_step(v, b, r);
            @(negedge clk);
            n_checks++;
            if (sample_valid !== exp_valid || overrun !== exp_overrun) $display("FAIL rand_flags cyc=%0d got=%0b/%0b want=%0b/%0b", i, sample_valid, overrun, exp_valid, exp_overrun); else n_pass++;
            if (exp_valid) begin
                n_checks++;
                if (sample !== 8'(exp_sample)) $display("FAIL rand_sample cyc=%0d got=%0h want=%0h", i, sample, exp_sample); else n_pass++;
            end
        end
        pdm_valid = 1'b0;
        sample_ready = 1'b1;
    endtask

    initial begin
        int n3, n5;
        n_checks = 0;
        n_pass = 0;
        reset_n = 1'b0;
        pdm_in = 1'b0;
        pdm_valid = 1'b0;
        sample_ready = 1'b1;
        model_reset();
        test_reset();
        test_all_zeros();
        test_all_ones();
        test_alternating(1, n3);
        test_backpressure();
        test_alternating(3, n5);
        n_checks++;
        if (n5 !== n3 || n3 !== 13) $display("FAIL gap_sample_count got=%0d want=%0d (13)", n5, n3); else n_pass++;
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
